// File: rtl/paint_tool_selector.sv
// Paint tool selector: synchronised and debounced colour switches plus erase and brush-size
// buttons, resolved into registered colour, erase and brush-size state with a change pulse.
module paint_tool_selector #(
   parameter int NUM_COLORS      = 7,
   parameter int COLOR_W         = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int SIZE_LEVELS     = 4,
   parameter int SIZE_W          = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_COLORS-1:0] sw,
   input  logic                  btn_tool,
   input  logic                  btn_size,
   output logic [COLOR_W-1:0]    color,
   output logic                  erase,
   output logic [SIZE_W-1:0]     brush_size,
   output logic                  changed
);

   localparam int unsigned N      = NUM_COLORS + 2;
   localparam int unsigned I_TOOL = NUM_COLORS;
   localparam int unsigned I_SIZE = NUM_COLORS + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SIZE_W-1:0] SIZE_MAX = SIZE_W'(SIZE_LEVELS - 1);

   logic [N-1:0]       w_raw;
   logic [N-1:0]       r_sync1;
   logic [N-1:0]       r_sync2;
   logic [N-1:0]       r_db;
   logic [CNT_W-1:0]   r_cnt [N];
   logic               r_tool_prev;
   logic               r_size_prev;

   logic [COLOR_W-1:0] r_sel;
   logic [COLOR_W-1:0] r_color;
   logic               r_erase;
   logic [SIZE_W-1:0]  r_size;
   logic               r_changed;

   logic               w_any;
   logic [COLOR_W-1:0] w_code;
   logic               w_tool_rise;
   logic               w_size_rise;
   logic [COLOR_W-1:0] w_sel_nxt;
   logic [COLOR_W-1:0] w_color_nxt;
   logic               w_erase_nxt;
   logic [SIZE_W-1:0]  w_size_nxt;
   logic               w_changed_nxt;

   assign w_raw = {btn_size, btn_tool, sw};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         for (int unsigned i = 0; i < N; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         // Counter only runs while the synced input disagrees with the accepted value.
         for (int unsigned i = 0; i < N; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_db[i]  <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_any  = 1'b0;
      w_code = '1;
      for (int unsigned i = 0; i < NUM_COLORS; i++) begin
         if (r_db[i]) begin
            w_any  = 1'b1;
            w_code = (i == 0) ? '1 : COLOR_W'(i);
         end
      end
   end

   assign w_tool_rise = r_db[I_TOOL] & ~r_tool_prev;
   assign w_size_rise = r_db[I_SIZE] & ~r_size_prev;

   always_comb begin
      w_sel_nxt   = w_any ? w_code : r_sel;
      w_erase_nxt = r_erase ^ w_tool_rise;
      w_size_nxt  = r_size;
      if (w_size_rise) w_size_nxt = (r_size == SIZE_MAX) ? '0 : r_size + SIZE_W'(1);
      w_color_nxt = w_erase_nxt ? '0 : w_sel_nxt;
      w_changed_nxt = (w_color_nxt != r_color) || (w_erase_nxt != r_erase) ||
                      (w_size_nxt != r_size);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tool_prev <= 1'b0;
         r_size_prev <= 1'b0;
         r_sel       <= '1;
         r_color     <= '1;
         r_erase     <= 1'b0;
         r_size      <= '0;
         r_changed   <= 1'b0;
      end else begin
         r_tool_prev <= r_db[I_TOOL];
         r_size_prev <= r_db[I_SIZE];
         r_sel       <= w_sel_nxt;
         r_color     <= w_color_nxt;
         r_erase     <= w_erase_nxt;
         r_size      <= w_size_nxt;
         r_changed   <= w_changed_nxt;
      end
   end

   assign color      = r_color;
   assign erase      = r_erase;
   assign brush_size = r_size;
   assign changed    = r_changed;

endmodule

// File: tb/tb_paint_tool_selector.sv
// Scoreboard bench for paint_tool_selector: expected output states are queued as stimulus
// is driven and popped when the DUT pulses changed.
module tb_paint_tool_selector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] sw;
   logic       btn_tool;
   logic       btn_size;
   logic [2:0] color;
   logic       erase;
   logic [1:0] brush_size;
   logic       changed;

   typedef struct packed {
      logic [2:0] c;
      logic       e;
      logic [1:0] s;
   } out_t;

   out_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         pulse_cnt = 0;
   int         pushed = 0;
   logic [2:0] m_sel;
   logic       m_erase;
   logic [1:0] m_size;

   paint_tool_selector #(
      .NUM_COLORS(7),
      .COLOR_W(3),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(20),
      .SIZE_LEVELS(4),
      .SIZE_W(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sw(sw),
      .btn_tool(btn_tool),
      .btn_size(btn_size),
      .color(color),
      .erase(erase),
      .brush_size(brush_size),
      .changed(changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      if (changed === 1'b1) pulse_cnt++;
   end

   function automatic out_t model_out();
      out_t o;
      o.c = m_erase ? 3'b000 : m_sel;
      o.e = m_erase;
      o.s = m_size;
      return o;
   endfunction

   function automatic out_t obs();
      return {color, erase, brush_size};
   endfunction

   task automatic push_exp();
      exp_q.push_back(model_out());
      pushed++;
   endtask

   task automatic pop_exp(output out_t e, output bit ok);
      ok = (exp_q.size() != 0);
      e  = ok ? exp_q.pop_front() : '0;
   endtask

   task automatic wait_changed(input int maxc, output int cyc, output bit seen);
      seen = 1'b0;
      cyc  = 0;
      for (int k = 1; k <= maxc; k++) begin
         @(posedge clk);
         #1;
         if (changed === 1'b1) begin
            seen = 1'b1;
            cyc  = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int p0;
      rst_n = 1'b0; sw = '0; btn_tool = 1'b0; btn_size = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({color, erase, brush_size, changed} !== 7'b111_0_00_0) begin
         failures++;
         $display("FAIL reset_values: got=%b exp=%b", {color, erase, brush_size, changed}, 7'b1110000);
      end
      rst_n = 1'b1;
      m_sel = 3'b111; m_erase = 1'b0; m_size = 2'd0;
      p0 = pulse_cnt;
      repeat (20) @(negedge clk);
      checks++;
      if (pulse_cnt !== p0) begin
         failures++; $display("FAIL idle_no_pulse: pulses=%0d exp=%0d", pulse_cnt - p0, 0);
      end
      checks++;
      if (obs() !== model_out()) begin
         failures++; $display("FAIL idle_values: got=%b exp=%b", obs(), model_out());
      end
   endtask

   task automatic test_color();
      out_t e; bit ok; bit seen; int cyc; int p0;
      @(negedge clk); sw = 7'b0000010; m_sel = 3'b001; push_exp();
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e) begin
         failures++; $display("FAIL color_red: got=%b exp=%b seen=%0d", obs(), e, seen);
      end
      checks++;
      if (cyc !== 7) begin
         failures++; $display("FAIL color_latency: got=%0d exp=%0d", cyc, 7);
      end
      @(posedge clk); #1;
      checks++;
      if (changed !== 1'b0) begin
         failures++; $display("FAIL pulse_width: changed=%b exp=0", changed);
      end
      @(negedge clk); sw = 7'b1000110; m_sel = 3'b110; push_exp();
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e) begin
         failures++; $display("FAIL color_priority: got=%b exp=%b seen=%0d", obs(), e, seen);
      end
      @(negedge clk); sw = '0; p0 = pulse_cnt;
      repeat (15) @(negedge clk);
      checks++;
      if (pulse_cnt !== p0 || color !== 3'b110) begin
         failures++; $display("FAIL color_hold: color=%b exp=110 pulses=%0d", color, pulse_cnt - p0);
      end
   endtask

   task automatic test_bounce();
      out_t e; bit ok; bit seen; int cyc; int p0;
      @(negedge clk); p0 = pulse_cnt; sw = 7'b0001000;
      repeat (3) @(negedge clk);
      sw = '0;
      repeat (15) @(negedge clk);
      checks++;
      if (pulse_cnt !== p0 || color !== 3'b110) begin
         failures++; $display("FAIL bounce_reject: color=%b exp=110 pulses=%0d", color, pulse_cnt - p0);
      end
      sw = 7'b0001000; m_sel = 3'b011; push_exp();
      repeat (4) @(negedge clk);
      sw = '0;
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e) begin
         failures++; $display("FAIL bounce_accept: got=%b exp=%b seen=%0d", obs(), e, seen);
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_erase();
      out_t e; bit ok; bit seen; int cyc; int p0;
      @(negedge clk); btn_tool = 1'b1; m_erase = 1'b1; push_exp();
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e) begin
         failures++; $display("FAIL erase_on: got=%b exp=%b seen=%0d", obs(), e, seen);
      end
      @(negedge clk); btn_tool = 1'b0; p0 = pulse_cnt;
      repeat (10) @(negedge clk);
      sw = 7'b0010000; m_sel = 3'b100;
      repeat (15) @(negedge clk);
      checks++;
      if (pulse_cnt !== p0 || color !== 3'b000) begin
         failures++; $display("FAIL erase_masks_sw: color=%b exp=000 pulses=%0d", color, pulse_cnt - p0);
      end
      btn_tool = 1'b1; m_erase = 1'b0; push_exp();
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e) begin
         failures++; $display("FAIL erase_off: got=%b exp=%b seen=%0d", obs(), e, seen);
      end
      @(negedge clk); btn_tool = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_size();
      out_t e; bit ok; bit seen; int cyc; int p0;
      logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); btn_size = 1'b1;
         m_size = (m_size == 2'd3) ? 2'd0 : m_size + 2'd1;
         push_exp();
         wait_changed(20, cyc, seen); pop_exp(e, ok);
         checks++;
         if (!ok || !seen || obs() !== e || brush_size !== seq[k]) begin
            failures++;
            $display("FAIL size_press%0d: got=%b exp=%b size=%0d want=%0d", k, obs(), e, brush_size, seq[k]);
         end
         @(negedge clk); btn_size = 1'b0; p0 = pulse_cnt;
         repeat (10) @(negedge clk);
         checks++;
         if (pulse_cnt !== p0) begin
            failures++; $display("FAIL size_release%0d: pulses=%0d exp=0", k, pulse_cnt - p0);
         end
      end
   endtask

   task automatic test_simultaneous();
      out_t e; bit ok; bit seen; int cyc; int p0;
      @(negedge clk); p0 = pulse_cnt;
      btn_tool = 1'b1; btn_size = 1'b1;
      m_erase = 1'b1; m_size = 2'd2; push_exp();
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e) begin
         failures++; $display("FAIL simul_apply: got=%b exp=%b seen=%0d", obs(), e, seen);
      end
      @(negedge clk); btn_tool = 1'b0; btn_size = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (pulse_cnt !== p0 + 1) begin
         failures++; $display("FAIL simul_single_pulse: pulses=%0d exp=%0d", pulse_cnt - p0, 1);
      end
      btn_tool = 1'b1; m_erase = 1'b0; push_exp();
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e) begin
         failures++; $display("FAIL simul_erase_off: got=%b exp=%b seen=%0d", obs(), e, seen);
      end
      @(negedge clk); btn_tool = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      out_t e; bit ok; bit seen; int cyc;
      @(negedge clk); sw = 7'b0100000; m_sel = 3'b101; push_exp();
      @(negedge clk); btn_tool = 1'b1; m_erase = 1'b1; push_exp();
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e) begin
         failures++; $display("FAIL b2b_first: got=%b exp=%b seen=%0d", obs(), e, seen);
      end
      @(posedge clk); #1; pop_exp(e, ok);
      checks++;
      if (!ok || changed !== 1'b1 || obs() !== e) begin
         failures++; $display("FAIL b2b_second: got=%b exp=%b changed=%b", obs(), e, changed);
      end
   endtask

   task automatic test_reset_mid();
      out_t e; bit ok; bit seen; int cyc;
      @(negedge clk); btn_size = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({color, erase, brush_size, changed} !== 7'b111_0_00_0) begin
         failures++;
         $display("FAIL reset_mid: got=%b exp=%b", {color, erase, brush_size, changed}, 7'b1110000);
      end
      btn_size = 1'b0; btn_tool = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_sel = 3'b101; m_erase = 1'b0; m_size = 2'd0; push_exp();
      wait_changed(20, cyc, seen); pop_exp(e, ok);
      checks++;
      if (!ok || !seen || obs() !== e || cyc !== 7) begin
         failures++; $display("FAIL reset_recover: got=%b exp=%b cyc=%0d want=7", obs(), e, cyc);
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_color();
      test_bounce();
      test_erase();
      test_size();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (pulse_cnt !== pushed || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL scoreboard_drain: pulses=%0d exp=%0d left=%0d", pulse_cnt, pushed, exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/paint_tool_selector.md
Name: paint_tool_selector

Overview:
- Parametrised successor to the paint colour selector in the VGA drawing pipeline.
- Synchronises and debounces NUM_COLORS colour switches and two push-buttons (erase toggle, brush-size cycle).
- Resolves the selection with a fixed priority and drives registered colour, erase and brush-size state to the pixel-write logic.
- Emits a one-cycle pulse whenever any output changes, so downstream cursor/UI logic can refresh.

Parameters:
- NUM_COLORS, 7: number of colour switches. Constraint: 1 <= NUM_COLORS <= 2^COLOR_W - 1.
- COLOR_W, 3: colour code width.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept an input change. Must be >= 1; benches use 4.
- CNT_W, 20: debounce counter width. Constraint: 2^CNT_W > DEBOUNCE_CYCLES.
- SIZE_LEVELS, 4: number of brush sizes. Must be >= 2.
- SIZE_W, 2: brush_size width. Constraint: 2^SIZE_W >= SIZE_LEVELS.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- sw  in  NUM_COLORS  raw colour switches, asynchronous
- btn_tool  in  1  raw erase-toggle button, asynchronous
- btn_size  in  1  raw brush-size button, asynchronous
- color  out  COLOR_W  active paint colour; 0 = white/erase
- erase  out  1  erase mode active
- brush_size  out  SIZE_W  brush size index, 0..SIZE_LEVELS-1
- changed  out  1  one-cycle pulse: color, erase or brush_size changed this cycle

Behaviour:
- Reset (async assert, sync deassert via clk domain):
  - Sync flops, debounced states and counters clear to 0.
  - Stored selection = all-ones (black); color = all-ones; erase = 0; brush_size = 0; changed = 0.
  - Reset mid-operation aborts all debounce counts and restores these values.
- Input conditioning, per input (NUM_COLORS + 2 instances):
  - 2-flop synchroniser feeds the debouncer.
  - Counter clears when the synced value equals the debounced value.
  - Otherwise the counter increments each cycle.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, the debounced value takes the synced value and the counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES is discarded.
- Latency: a clean raw edge sampled at clk edge 1 reaches the debounced value at edge DEBOUNCE_CYCLES+2 and the outputs at edge DEBOUNCE_CYCLES+3.
- Colour resolution (combinational from debounced sw, registered into the stored selection):
  - The highest-index asserted switch wins.
  - sw[0] maps to all-ones (black); sw[i], i >= 1, maps to code i.
  - With the default 3-bit width: 1 red, 2 orange, 3 yellow, 4 green, 5 blue, 6 purple.
  - No switch asserted: the stored selection holds its previous value.
- Erase:
  - A debounced btn_tool rising edge (debounced 0->1 versus its previous-cycle value) toggles erase.
  - erase = 1: color = 0. The stored selection keeps tracking switches but is not driven out.
  - erase -> 0: color returns to the current stored selection on the same edge.
- Brush size:
  - A debounced btn_size rising edge increments brush_size.
  - SIZE_LEVELS-1 wraps to 0.
  - Falling edges are ignored.
- Simultaneous events:
  - Tool edge, size edge and switch change on the same cycle are all applied on that edge.
  - changed pulses once.
- Buttons held through reset: after rst_n deasserts, the debounced value rises after the debounce delay and counts as one rising edge.
- changed:
  - Registered; 1 on the cycle after any of color, erase or brush_size took a new value, else 0.
  - A switch change while erase = 1 does not alter color, so it produces no pulse.
  - Back-to-back changes produce back-to-back pulses.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- DEBOUNCE_CYCLES=4, reset then idle 20 cycles -> color=3'b111, erase=0, brush_size=0, changed never asserted.
- sw=7'b0000010 held -> color=3'b001 exactly 7 edges after sw sampled, changed high 1 cycle. Then sw=7'b1000110 -> color=3'b110. Then sw=0 -> color holds 3'b110, no pulse.
- sw[3] pulsed high 3 cycles then low (bounce) -> color unchanged, no changed pulse. Same pulse held 4 cycles -> color=3'b011.
- btn_tool clean press -> erase=1, color=0. While erasing, set sw=7'b0010000 -> color stays 0, no pulse. Second press -> erase=0, color=3'b100.
- btn_size pressed 5 times (SIZE_LEVELS=4) -> brush_size sequence 1,2,3,0,1, one changed pulse per press. btn_tool and btn_size released/pressed on the same cycle -> both applied, single pulse.
- Assert rst_n=0 mid-debounce with erase=1 and brush_size=2 -> outputs immediately 3'b111/0/0. Deassert with sw[5] still high -> color=3'b101 after debounce delay.
